// File: rtl/llc_input_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : llc_input_arbiter_if
// Four input channels, stall masks and the held-message output of the
// LLC DECODE front-end arbiter.
// Rev    : 1.0
// ============================================================================
interface llc_input_arbiter_if #(
  parameter int DATA_W = 160
);
  logic              rsp_in_valid;
  logic              rsp_in_ready;
  logic [DATA_W-1:0] rsp_in_data;
  logic              rst_tb_valid;
  logic              rst_tb_ready;
  logic [DATA_W-1:0] rst_tb_data;
  logic              req_in_valid;
  logic              req_in_ready;
  logic [DATA_W-1:0] req_in_data;
  logic              dma_req_in_valid;
  logic              dma_req_in_ready;
  logic [DATA_W-1:0] dma_req_in_data;
  logic              req_stall;
  logic              dma_stall;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              starve_force;

  // Arbiter side
  modport slave (
    input  rsp_in_valid, rsp_in_data, rst_tb_valid, rst_tb_data,
           req_in_valid, req_in_data, dma_req_in_valid, dma_req_in_data,
           req_stall, dma_stall, out_ready,
    output rsp_in_ready, rst_tb_ready, req_in_ready, dma_req_in_ready,
           out_valid, out_data, out_src, starve_force
  );

  // Sender / DECODE side
  modport master (
    output rsp_in_valid, rsp_in_data, rst_tb_valid, rst_tb_data,
           req_in_valid, req_in_data, dma_req_in_valid, dma_req_in_data,
           req_stall, dma_stall, out_ready,
    input  rsp_in_ready, rst_tb_ready, req_in_ready, dma_req_in_ready,
           out_valid, out_data, out_src, starve_force
  );
endinterface
`default_nettype wire

// File: rtl/llc_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module : llc_input_arbiter
// Registered arbiter feeding DECODE: fixed priority rsp > rst > RR(req,dma),
// per-channel stall masks and a starvation guard for the request channels.
// Rev    : 1.0
// ============================================================================
module llc_input_arbiter #(
  parameter int DATA_W   = 160,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  llc_input_arbiter_if.slave bus
);
  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(MAX_WAIT);
  localparam logic [1:0]       SRC_RSP = 2'd0;
  localparam logic [1:0]       SRC_RST = 2'd1;
  localparam logic [1:0]       SRC_REQ = 2'd2;
  localparam logic [1:0]       SRC_DMA = 2'd3;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_src_q, out_src_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic       load;
  logic       e_rsp, e_rst, e_req, e_dma, any_rr;
  logic       rr_pick_dma;
  logic       starve_force;
  logic       grant_vld;
  logic [1:0] grant;

  // Grant selection; only meaningful while the output register can load
  always_comb begin
    load         = !out_valid_q || bus.out_ready;
    e_rsp        = bus.rsp_in_valid;
    e_rst        = bus.rst_tb_valid;
    e_req        = bus.req_in_valid & !bus.req_stall;
    e_dma        = bus.dma_req_in_valid & !bus.dma_stall;
    any_rr       = e_req | e_dma;
    rr_pick_dma  = e_dma & (!e_req | rr_ptr_q);
    starve_force = (starve_cnt_q == C_MAX) & any_rr;
    grant_vld    = 1'b0;
    grant        = SRC_RSP;
    if (load) begin
      if (starve_force) begin
        grant_vld = 1'b1;
        grant     = rr_pick_dma ? SRC_DMA : SRC_REQ;
      end else if (e_rsp) begin
        grant_vld = 1'b1;
        grant     = SRC_RSP;
      end else if (e_rst) begin
        grant_vld = 1'b1;
        grant     = SRC_RST;
      end else if (any_rr) begin
        grant_vld = 1'b1;
        grant     = rr_pick_dma ? SRC_DMA : SRC_REQ;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_src_d = grant;
        case (grant)
          SRC_RSP: out_data_d = bus.rsp_in_data;
          SRC_RST: out_data_d = bus.rst_tb_data;
          SRC_REQ: out_data_d = bus.req_in_data;
          default: out_data_d = bus.dma_req_in_data;
        endcase
      end
    end
    if (grant_vld && grant == SRC_REQ) begin
      rr_ptr_d = 1'b1;
    end else if (grant_vld && grant == SRC_DMA) begin
      rr_ptr_d = 1'b0;
    end
    // A pending request that loses to rsp/rst counts one more lost cycle
    if (!any_rr) begin
      starve_cnt_d = '0;
    end else if (grant_vld && grant[1]) begin
      starve_cnt_d = '0;
    end else if (grant_vld && starve_cnt_q != C_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= SRC_RSP;
      rr_ptr_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.rsp_in_ready     = grant_vld && grant == SRC_RSP;
  assign bus.rst_tb_ready     = grant_vld && grant == SRC_RST;
  assign bus.req_in_ready     = grant_vld && grant == SRC_REQ;
  assign bus.dma_req_in_ready = grant_vld && grant == SRC_DMA;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_data         = out_data_q;
  assign bus.out_src          = out_src_q;
  assign bus.starve_force     = starve_force;
endmodule
`default_nettype wire

// File: tb/tb_llc_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_llc_input_arbiter
// Self-checking bench: directed vector table, corner sequences, random traffic.
// Rev    : 1.0
// ============================================================================
module tb_llc_input_arbiter;
  localparam int DATA_W   = 160;
  localparam int MAX_WAIT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  llc_input_arbiter_if #(.DATA_W(DATA_W)) bus ();
  llc_input_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // v: {dma, req, rst, rsp}; st: {dma_stall, req_stall}
  typedef struct {
    logic [3:0] v;
    logic [1:0] st;
    logic       ordy;
    logic [7:0] dat;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_src;
  } vec_t;
  vec_t tbl[11];

  logic [3:0]        t_v;
  logic [1:0]        t_st;
  logic              t_ordy;
  logic [DATA_W-1:0] chdata[4];

  // Reference model: held message, which request channel is favoured next,
  // and how many cycles a pending request has lost in a row
  logic              m_ov;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_src;
  logic              m_fav_dma;
  int                m_lost;
  bit                m_el[4];
  bit                m_load, m_force;
  int                m_pick;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] rdy;
  logic       frc;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.rsp_in_valid     = t_v[0];
    bus.rst_tb_valid     = t_v[1];
    bus.req_in_valid     = t_v[2];
    bus.dma_req_in_valid = t_v[3];
    bus.rsp_in_data      = chdata[0];
    bus.rst_tb_data      = chdata[1];
    bus.req_in_data      = chdata[2];
    bus.dma_req_in_data  = chdata[3];
    bus.req_stall        = t_st[0];
    bus.dma_stall        = t_st[1];
    bus.out_ready        = t_ordy;
  endtask

  task automatic model_reset();
    m_ov      = 1'b0;
    m_data    = '0;
    m_src     = 2'd0;
    m_fav_dma = 1'b0;
    m_lost    = 0;
  endtask

  task automatic model_comb();
    int order[4];
    int n;
    int first;
    m_el[0] = t_v[0];
    m_el[1] = t_v[1];
    m_el[2] = t_v[2] && !t_st[0];
    m_el[3] = t_v[3] && !t_st[1];
    m_load  = !m_ov || t_ordy;
    m_force = (m_lost == MAX_WAIT) && (m_el[2] || m_el[3]);
    first   = m_fav_dma ? 3 : 2;
    n       = 0;
    if (!m_force) begin
      order[0] = 0;
      order[1] = 1;
      n = 2;
    end
    order[n]   = first;
    order[n+1] = 5 - first;
    n += 2;
    m_pick = -1;
    if (m_load)
      for (int k = 0; k < n; k++)
        if (m_pick < 0 && m_el[order[k]]) m_pick = order[k];
  endtask

  task automatic model_clock();
    if (m_load) begin
      if (m_pick >= 0) begin
        m_ov   = 1'b1;
        m_data = chdata[m_pick];
        m_src  = 2'(m_pick);
      end else begin
        m_ov = 1'b0;
      end
    end
    if (m_pick == 2) m_fav_dma = 1'b1;
    else if (m_pick == 3) m_fav_dma = 1'b0;
    if (!(m_el[2] || m_el[3])) m_lost = 0;
    else if (m_pick >= 2) m_lost = 0;
    else if (m_pick >= 0 && m_lost < MAX_WAIT) m_lost++;
  endtask

  // One clock: apply inputs, check handshake outputs, clock, check held message
  task automatic step(output logic [3:0] r, output logic f);
    drive();
    #1;
    model_comb();
    r = {bus.dma_req_in_ready, bus.req_in_ready, bus.rst_tb_ready, bus.rsp_in_ready};
    f = bus.starve_force;
    for (int k = 0; k < 4; k++)
      check($sformatf("ready[%0d]", k), DATA_W'(r[k]), DATA_W'(m_pick == k));
    check("starve_force", DATA_W'(f), DATA_W'(m_force));
    @(posedge clk);
    model_clock();
    #1;
    check("out_valid", DATA_W'(bus.out_valid), DATA_W'(m_ov));
    check("out_src", DATA_W'(bus.out_src), DATA_W'(m_src));
    check("out_data", bus.out_data, m_data);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset out_valid", DATA_W'(bus.out_valid), '0);
    check("reset out_src", DATA_W'(bus.out_src), '0);
    check("reset out_data", bus.out_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_dat(input logic [7:0] d);
    for (int c = 0; c < 4; c++) chdata[c] = DATA_W'(d) | (DATA_W'(c) << 12);
  endtask

  initial begin
    t_v = '0; t_st = '0; t_ordy = 1'b1;
    for (int c = 0; c < 4; c++) chdata[c] = '0;
    drive();
    model_reset();
    #2;
    apply_reset();

    tbl[0]  = '{4'b0100, 2'b00, 1'b1, 8'hA5, 4'b0100, 1'b1, 2'd2};
    tbl[1]  = '{4'b1100, 2'b00, 1'b1, 8'hB0, 4'b1000, 1'b1, 2'd3};
    tbl[2]  = '{4'b1100, 2'b00, 1'b1, 8'hB1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1100, 2'b01, 1'b1, 8'hB2, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1100, 2'b00, 1'b1, 8'hB3, 4'b0100, 1'b1, 2'd2};
    tbl[5]  = '{4'b0001, 2'b00, 1'b0, 8'hB3, 4'b0000, 1'b1, 2'd2};
    tbl[6]  = '{4'b0001, 2'b00, 1'b1, 8'hC0, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 2'b00, 1'b1, 8'hC0, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{4'b0010, 2'b00, 1'b1, 8'hC1, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{4'b1111, 2'b00, 1'b1, 8'hC2, 4'b0001, 1'b1, 2'd0};
    tbl[10] = '{4'b1011, 2'b00, 1'b1, 8'hC3, 4'b0001, 1'b1, 2'd0};

    for (int i = 0; i < 11; i++) begin
      t_v = tbl[i].v; t_st = tbl[i].st; t_ordy = tbl[i].ordy;
      set_dat(tbl[i].dat);
      step(rdy, frc);
      check($sformatf("tbl%0d ready", i), DATA_W'(rdy), DATA_W'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d out_valid", i), DATA_W'(bus.out_valid), DATA_W'(tbl[i].exp_ov));
      check($sformatf("tbl%0d out_src", i), DATA_W'(bus.out_src), DATA_W'(tbl[i].exp_src));
      if (tbl[i].exp_ov)
        check($sformatf("tbl%0d out_data", i), bus.out_data, chdata[tbl[i].exp_src]);
    end

    // Starvation: rsp wins MAX_WAIT times, then req is forced through
    apply_reset();
    t_v = 4'b1111; t_st = 2'b00; t_ordy = 1'b1;
    set_dat(8'h5A);
    for (int i = 0; i <= MAX_WAIT + 1; i++) begin
      step(rdy, frc);
      check($sformatf("starve%0d src", i), DATA_W'(bus.out_src), DATA_W'((i == MAX_WAIT) ? 2 : 0));
      check($sformatf("starve%0d flag", i), DATA_W'(frc), DATA_W'(i == MAX_WAIT));
    end

    // Downstream backpressure holds the message and blocks every ready
    t_v = 4'b0001; t_ordy = 1'b1;
    chdata[0] = DATA_W'(8'h11);
    step(rdy, frc);
    check("hold load", bus.out_data, DATA_W'(8'h11));
    chdata[0] = DATA_W'(8'h22);
    t_ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(rdy, frc);
      check($sformatf("hold%0d ready", i), DATA_W'(rdy), '0);
      check($sformatf("hold%0d data", i), bus.out_data, DATA_W'(8'h11));
    end
    t_ordy = 1'b1;
    step(rdy, frc);
    check("release ready", DATA_W'(rdy), DATA_W'(4'b0001));
    check("release data", bus.out_data, DATA_W'(8'h22));

    // Asynchronous reset while a message is held, then a fresh req/dma tie
    apply_reset();
    t_v = 4'b1100; t_ordy = 1'b1;
    set_dat(8'h77);
    step(rdy, frc);
    check("post-reset tie src", DATA_W'(bus.out_src), DATA_W'(2'd2));

    for (int i = 0; i < 600; i++) begin
      t_v = 4'($urandom);
      if ((i % 150) < 30) t_v = t_v | 4'b0101;
      t_st   = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      t_ordy = ($urandom_range(3) != 0);
      for (int c = 0; c < 4; c++)
        chdata[c] = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step(rdy, frc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
